// File: rtl/megnetic_freq_avg_pack.sv
// Magnetic frequency averager: samples five 16-bit channels on a fixed tick, box-car
// averages 2**AVG_LOG2 samples per channel and streams the averages as one checked frame.
module megnetic_freq_avg_pack #(
    parameter int unsigned SAMPLE_CYCLES = 100_000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter logic [15:0] FREQ_MIN      = 16'd100,
    parameter logic [15:0] FREQ_MAX      = 16'd60000
) (
    input  logic        clk_100m,
    input  logic        log_rst_n,
    input  logic        megnetic_freq_en,
    input  logic [79:0] megnetic_freq,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_ch,
    output logic [15:0] out_data,
    output logic        out_alarm,
    output logic        out_last,
    output logic [7:0]  overrun_cnt
);
    localparam int unsigned NCH  = 5;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = DW + AVG_LOG2;
    localparam int unsigned DIVW = $clog2(SAMPLE_CYCLES);
    localparam int unsigned SW   = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_CYCLES - 1);
    localparam logic [SW-1:0]   SMP_LAST = SW'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]      CH_LAST  = 3'(NCH - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;

    state_e          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [SW-1:0]   smp_q, smp_d;
    logic [AW-1:0]   acc_q  [NCH];
    logic [AW-1:0]   acc_d  [NCH];
    logic [AW-1:0]   sum_c  [NCH];
    logic [DW-1:0]   avg_q  [NCH];
    logic [DW-1:0]   avg_d  [NCH];
    logic [DW-1:0]   hold_q [NCH];
    logic [DW-1:0]   hold_d [NCH];
    logic            block_done_q, block_done_d;
    logic            out_valid_q, out_valid_d;
    logic [2:0]      out_ch_q, out_ch_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_alarm_q, out_alarm_d;
    logic            out_last_q, out_last_d;
    logic [7:0]      overrun_q, overrun_d;
    logic            tick_c;
    logic [2:0]      ch_nxt_c;

    function automatic logic out_of_range(input logic [DW-1:0] v);
        return (v < FREQ_MIN) || (v > FREQ_MAX);
    endfunction

    assign tick_c   = megnetic_freq_en && (div_q == DIV_LAST);
    assign ch_nxt_c = out_ch_q + 3'd1;

    // Running sum including the sample present on the input this cycle
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum_c[i] = acc_q[i] + AW'(megnetic_freq[DW*i +: DW]);
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = tick_c ? '0 : div_q + DIVW'(1);
        smp_d        = smp_q;
        acc_d        = acc_q;
        avg_d        = avg_q;
        hold_d       = hold_q;
        block_done_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_ch_d     = out_ch_q;
        out_data_d   = out_data_q;
        out_alarm_d  = out_alarm_q;
        out_last_d   = out_last_q;
        overrun_d    = overrun_q;

        // Accumulation runs on every tick regardless of the frame state
        if (tick_c) begin
            if (smp_q == SMP_LAST) begin
                smp_d        = '0;
                block_done_d = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    avg_d[i] = DW'(sum_c[i] >> AVG_LOG2);
                    acc_d[i] = '0;
                end
            end else begin
                smp_d = smp_q + SW'(1);
                for (int i = 0; i < NCH; i++) begin
                    acc_d[i] = sum_c[i];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (megnetic_freq_en) state_d = COLLECT;
            end
            COLLECT: begin
                if (block_done_q) begin
                    hold_d      = avg_q;
                    out_valid_d = 1'b1;
                    out_ch_d    = '0;
                    out_data_d  = avg_q[0];
                    out_alarm_d = out_of_range(avg_q[0]);
                    out_last_d  = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // A block finishing mid-frame is dropped; the frame in flight is kept
                if (block_done_q && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
                if (out_ready) begin
                    if (out_ch_q == CH_LAST) begin
                        out_valid_d = 1'b0;
                        out_ch_d    = '0;
                        out_data_d  = '0;
                        out_alarm_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = COLLECT;
                    end else begin
                        out_ch_d    = ch_nxt_c;
                        out_data_d  = hold_q[ch_nxt_c];
                        out_alarm_d = out_of_range(hold_q[ch_nxt_c]);
                        out_last_d  = (ch_nxt_c == CH_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable acts as a synchronous clear of everything except the overrun count
        if (!megnetic_freq_en) begin
            state_d      = IDLE;
            div_d        = '0;
            smp_d        = '0;
            block_done_d = 1'b0;
            out_valid_d  = 1'b0;
            out_ch_d     = '0;
            out_data_d   = '0;
            out_alarm_d  = 1'b0;
            out_last_d   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_d[i]  = '0;
                avg_d[i]  = '0;
                hold_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (!log_rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            smp_q        <= '0;
            block_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            out_alarm_q  <= 1'b0;
            out_last_q   <= 1'b0;
            overrun_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                avg_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            smp_q        <= smp_d;
            block_done_q <= block_done_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_data_q   <= out_data_d;
            out_alarm_q  <= out_alarm_d;
            out_last_q   <= out_last_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= acc_d[i];
                avg_q[i]  <= avg_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_data    = out_data_q;
    assign out_alarm   = out_alarm_q;
    assign out_last    = out_last_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_megnetic_freq_avg_pack.sv
// Scoreboard bench for megnetic_freq_avg_pack: expected frame words are queued as each block
// is fed and compared as the DUT hands them over.
module tb_megnetic_freq_avg_pack;
    localparam int unsigned S  = 10;
    localparam int unsigned NS = 4;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
        logic        alarm;
        logic        last;
    } word_t;

    logic        clk_100m = 1'b0;
    logic        log_rst_n;
    logic        megnetic_freq_en;
    logic [79:0] megnetic_freq;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ch;
    logic [15:0] out_data;
    logic        out_alarm;
    logic        out_last;
    logic [7:0]  overrun_cnt;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    hs_cnt  = 0;
    int    base    = 0;
    int    blk [5][NS];
    word_t exp_q [$];
    bit    lat_pending = 1'b0;
    bit    stall_prev  = 1'b0;
    bit    last_prev   = 1'b0;
    logic [31:0] stall_word = '0;
    int    t2_vals [4] = '{99, 100, 60000, 60001};

    always #5 clk_100m = ~clk_100m;

    megnetic_freq_avg_pack #(
        .SAMPLE_CYCLES(S),
        .AVG_LOG2     (2),
        .FREQ_MIN     (16'd100),
        .FREQ_MAX     (16'd60000)
    ) dut (
        .clk_100m        (clk_100m),
        .log_rst_n       (log_rst_n),
        .megnetic_freq_en(megnetic_freq_en),
        .megnetic_freq   (megnetic_freq),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ch          (out_ch),
        .out_data        (out_data),
        .out_alarm       (out_alarm),
        .out_last        (out_last),
        .overrun_cnt     (overrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_avg(input int c);
        int sum = 0;
        for (int s = 0; s < NS; s++) sum += blk[c][s];
        return sum >> 2;
    endfunction

    function automatic logic exp_alarm(input int v);
        return (v < 100) || (v > 60000);
    endfunction

    task automatic set_blk(input int c, input int v0, input int v1, input int v2, input int v3);
        blk[c][0] = v0; blk[c][1] = v1; blk[c][2] = v2; blk[c][3] = v3;
    endtask

    task automatic set_const(input int c, input int v);
        set_blk(c, v, v, v, v);
    endtask

    task automatic push_frame(input int n);
        word_t w;
        for (int c = 0; c < n; c++) begin
            w.ch    = 3'(c);
            w.data  = 16'(exp_avg(c));
            w.alarm = exp_alarm(exp_avg(c));
            w.last  = (c == 4);
            exp_q.push_back(w);
        end
    endtask

    task automatic step();
        @(posedge clk_100m);
        #2;
        if (lat_pending) begin
            lat_pending = 1'b0;
            check("latency_valid", 32'(out_valid), 32'd1);
        end
    endtask

    // One sample per S-cycle window, aligned to the divider started at enable/reset release
    task automatic feed_block(input bit chk_lat, input int npush);
        push_frame(npush);
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < 5; c++) megnetic_freq[16*c +: 16] = 16'(blk[c][s]);
            repeat (S) step();
        end
        if (chk_lat) begin
            check("latency_pre", 32'(out_valid), 32'd0);
            lat_pending = 1'b1;
        end
    endtask

    // Output monitor: scoreboard pops, hold-stability under stall, gap after last word
    always @(negedge clk_100m) begin
        word_t w;
        if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_word", 32'({out_ch, out_data, out_alarm, out_last}), stall_word);
        end
        if (last_prev) check("gap_after_last", 32'(out_valid), 32'd0);
        last_prev = 1'b0;
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                w = exp_q.pop_front();
                check("word_ch", 32'(out_ch), 32'(w.ch));
                check("word_data", 32'(out_data), 32'(w.data));
                check("word_alarm", 32'(out_alarm), 32'(w.alarm));
                check("word_last", 32'(out_last), 32'(w.last));
            end
            last_prev = out_last;
        end
        stall_prev = out_valid && !out_ready && megnetic_freq_en;
        stall_word = 32'({out_ch, out_data, out_alarm, out_last});
    end

    initial begin
        int n;
        log_rst_n        = 1'b0;
        megnetic_freq_en = 1'b1;
        out_ready        = 1'b1;
        megnetic_freq    = '0;
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_alarm", 32'(out_alarm), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);

        // Averaging with truncation and out-of-window channels
        set_blk(0, 100, 200, 300, 401);
        set_const(1, 1000);
        set_blk(2, 5000, 5001, 5002, 5003);
        set_const(3, 50);
        set_const(4, 65535);
        log_rst_n = 1'b1;
        feed_block(1'b1, 5);

        set_const(0, 7);
        set_blk(1, 1, 2, 3, 4);
        set_const(2, 30000);
        set_const(3, 60000);
        set_const(4, 100);
        feed_block(1'b1, 5);
        base = hs_cnt;

        // Stall the previous frame at ch2 for 20 cycles while the next block is fed
        set_const(0, 1111);
        set_const(1, 2222);
        set_const(2, 3333);
        set_const(3, 4444);
        set_blk(4, 10, 20, 30, 41);
        fork
            feed_block(1'b1, 5);
            begin
                int k = 0;
                while ((hs_cnt - base) < 2 && k < 50) begin
                    @(posedge clk_100m);
                    #2;
                    k++;
                end
                check("stall_hs", 32'(hs_cnt - base), 32'd2);
                out_ready = 1'b0;
                repeat (20) begin
                    @(posedge clk_100m);
                    #2;
                end
                out_ready = 1'b1;
            end
        join

        // Two further blocks finish while the frame above is held: both are dropped
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) set_const(c, 9000 + c);
        feed_block(1'b0, 0);
        for (int c = 0; c < 5; c++) set_const(c, 8000 + c);
        feed_block(1'b0, 0);
        out_ready = 1'b1;

        // Alarm window boundaries on ch2
        for (int t = 0; t < 4; t++) begin
            set_const(0, 500);
            set_const(1, 600);
            set_const(2, t2_vals[t]);
            set_const(3, 700);
            set_const(4, 800);
            feed_block(1'b1, 5);
            if (t == 0) check("overrun_cnt", 32'(overrun_cnt), 32'd2);
        end

        // Enable dropped while ch2 is presented; two stray samples land before the drop
        for (int c = 0; c < 5; c++) set_const(c, 11 * (c + 1));
        feed_block(1'b1, 2);
        for (int c = 0; c < 5; c++) megnetic_freq[16*c +: 16] = 16'd40000;
        base = hs_cnt;
        n = 0;
        while ((hs_cnt - base) < 2 && n < 50) begin
            step();
            n++;
        end
        check("drop_hs", 32'(hs_cnt - base), 32'd2);
        out_ready = 1'b0;
        repeat (25) step();
        check("drop_ch_pre", 32'(out_ch), 32'd2);
        megnetic_freq_en = 1'b0;
        step();
        check("drop_valid", 32'(out_valid), 32'd0);
        check("drop_ch", 32'(out_ch), 32'd0);
        check("drop_data", 32'(out_data), 32'd0);
        check("drop_overrun_kept", 32'(overrun_cnt), 32'd2);
        repeat (3) step();
        check("drop_idle_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        set_blk(0, 1000, 1001, 1002, 1003);
        set_const(1, 20);
        set_const(2, 60001);
        set_const(3, 150);
        set_blk(4, 3, 3, 3, 4);
        megnetic_freq_en = 1'b1;
        feed_block(1'b1, 5);
        step();

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("final_overrun", 32'(overrun_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
